uart_byte_rx: RTL and testbench

Receives 8N1 asynchronous serial frames on uart_rx and presents each byte with a one-cycle done strobe. It is the receive-side counterpart of uart_byte_tx and shares its baud_set encoding, so the two can be looped back for board test. The block sits between the board RX pin and the consuming logic, such as VIO/ILA capture or an echo path to uart_byte_tx.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_bit_timer.sv | 40 ++++
 rtl/uart_byte_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_byte_rx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud_set encoding, bit-period divisor helper,
// majority vote helper and the receive/transmit FSM state encoding.
package uart_pkg;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  localparam int DIV_W = 16;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_fsm_e;

  // Unused codes 5..7 fall back to 9600 so a mis-set switch still gives a usable rate.
  function automatic logic [DIV_W-1:0] baud_div(input int clk_freq, input logic [2:0] baud_set);
    logic [DIV_W-1:0] div;
    case (baud_set)
      BAUD_19200:  div = DIV_W'(clk_freq / 19200);
      BAUD_38400:  div = DIV_W'(clk_freq / 38400);
      BAUD_57600:  div = DIV_W'(clk_freq / 57600);
      BAUD_115200: div = DIV_W'(clk_freq / 115200);
      default:     div = DIV_W'(clk_freq / 9600);
    endcase
    return div;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter for the UART receiver: counts 0..div-1 and flags the
// three mid-bit sample points, the decision point and the period wrap.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic [DIV_W-1:0] div_cnt,
  output logic [2:0]       sample,
  output logic             decide,
  output logic             wrap
);

  logic [DIV_W-1:0] half;

  assign half = div >> 1;

  // Period counter; load realigns it to the start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (load || wrap) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Strobe decode from the current count.
  always_comb begin
    sample[0] = (div_cnt == half - DIV_W'(1));
    sample[1] = (div_cnt == half);
    sample[2] = (div_cnt == half + DIV_W'(1));
    decide    = sample[2];
    wrap      = (div_cnt == div - DIV_W'(1));
  end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with 3-sample majority voting, false-start rejection
// and an early return to IDLE at mid stop bit for back-to-back frames.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_set,
  input  logic       uart_rx,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       uart_state
);

  logic             rx_meta, rx_s, rx_d;
  logic             start_edge;
  logic [1:0]       votes;
  logic             third, maj;
  uart_fsm_e        state, state_n;
  logic [DIV_W-1:0] div_lat, div_lat_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       data_n;
  logic             done_n, err_n, busy_n;
  logic             load;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       sample;
  logic             decide, wrap;
  logic             unused_cnt;

  uart_bit_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .div     (div_lat),
    .div_cnt (div_cnt),
    .sample  (sample),
    .decide  (decide),
    .wrap    (wrap)
  );

  assign unused_cnt = ^div_cnt;
  assign start_edge = rx_d & ~rx_s;
  // The third sample is taken live in the decision cycle itself.
  assign third      = sample[2] & rx_s;
  assign maj        = majority3(votes[0], votes[1], third);

  // Input synchronizer plus edge-detect delay, idle high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // Capture the first two mid-bit samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      votes <= 2'b11;
    end else begin
      if (sample[0]) votes[0] <= rx_s;
      if (sample[1]) votes[1] <= rx_s;
    end
  end

  // FSM next state and next register values.
  always_comb begin
    state_n   = state;
    div_lat_n = div_lat;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    data_n    = data_byte;
    done_n    = 1'b0;
    err_n     = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_n   = START;
          load      = 1'b1;
          div_lat_n = baud_div(CLK_FREQ, baud_set);
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (decide && maj) begin
          state_n = IDLE;
        end else if (wrap) begin
          state_n   = DATA;
          bit_cnt_n = 3'd0;
        end else begin
          state_n = START;
        end
      end
      DATA: begin
        if (decide) begin
          shift_n = {maj, shift[7:1]};
        end else begin
          shift_n = shift;
        end
        if (wrap && (bit_cnt == 3'd7)) begin
          state_n = STOP;
        end else if (wrap) begin
          bit_cnt_n = bit_cnt + 3'd1;
        end else begin
          state_n = DATA;
        end
      end
      STOP: begin
        if (decide && maj) begin
          state_n = IDLE;
          data_n  = shift;
          done_n  = 1'b1;
        end else if (decide) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else begin
          state_n = STOP;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE) | done_n | err_n;
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      div_lat    <= baud_div(CLK_FREQ, BAUD_9600);
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      data_byte  <= 8'h00;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      uart_state <= 1'b0;
    end else begin
      state      <= state_n;
      div_lat    <= div_lat_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      data_byte  <= data_n;
      rx_done    <= done_n;
      frame_err  <= err_n;
      uart_state <= busy_n;
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: drives 8N1 frames bit by bit and
// checks results against a frame-level model of the receiver.
`timescale 1ns/1ps
module tb_uart_byte_rx;

  localparam int CLK_FREQ = 25_000_000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] baud_set = 3'd4;
  logic       uart_rx = 1'b1;
  logic [7:0] data_byte;
  logic       rx_done, frame_err, uart_state;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int unsigned fall_cyc = 0;
  logic [7:0] exp_last = 8'h00;

  logic [7:0]  done_q[$];
  int unsigned done_t[$];
  int err_pulses = 0, overlap = 0, wide = 0, state_hi = 0;
  logic prev_done = 1'b0, prev_err = 1'b0;

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_set   (baud_set),
    .uart_rx    (uart_rx),
    .data_byte  (data_byte),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .uart_state (uart_state)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rx_done) begin
      done_q.push_back(data_byte);
      done_t.push_back(cyc);
    end
    if (frame_err) err_pulses++;
    if (rx_done && frame_err) overlap++;
    if ((rx_done && prev_done) || (frame_err && prev_err)) wide++;
    prev_done = rx_done;
    prev_err  = frame_err;
    if (uart_state) state_hi++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int exp_div(input logic [2:0] bs);
    int rates[5] = '{9600, 19200, 38400, 57600, 115200};
    if (bs > 3'd4) return CLK_FREQ / 9600;
    return CLK_FREQ / rates[bs];
  endfunction

  task automatic clear_mon();
    done_q.delete();
    done_t.delete();
    err_pulses = 0;
    overlap    = 0;
    wide       = 0;
    state_hi   = 0;
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame; glitch inverts the line for one clock at mid data bit.
  task automatic send_frame(input logic [7:0] b, input int div, input logic stop_bit, input logic glitch);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    fall_cyc = cyc;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < div; i++) begin
        uart_rx = (glitch && k >= 1 && k <= 8 && i == div / 2) ? ~bits[k] : bits[k];
        @(negedge clk);
      end
    end
    uart_rx = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (data_byte !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 00", data_byte); end
    checks++; if (rx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", rx_done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", frame_err); end
    checks++; if (uart_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %0b expected 0", uart_state); end
    reset = 1'b0;
    idle(20);
  endtask

  task automatic test_single();
    int d, lo, lat;
    logic [7:0] got;
    baud_set = 3'd4;
    d = exp_div(3'd4);
    clear_mon();
    send_frame(8'hA5, d, 1'b1, 1'b0);
    idle(4);
    exp_last = 8'hA5;
    got = (done_q.size() > 0) ? done_q[0] : 8'hxx;
    lat = (done_t.size() > 0) ? int'(done_t[0] - fall_cyc) : -1;
    lo = 9 * d + d / 2;
    checks++; if (done_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", done_q.size()); end
    checks++; if (got !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h expected a5", got); end
    checks++; if (err_pulses != 0) begin errors++; $display("FAIL single_err: got %0d expected 0", err_pulses); end
    checks++; if (lat < lo || lat > lo + 6) begin errors++; $display("FAIL single_latency: got %0d expected %0d..%0d", lat, lo, lo + 6); end
    checks++; if (uart_state !== 1'b0) begin errors++; $display("FAIL single_state: got %0b expected 0", uart_state); end
    checks++; if (wide != 0) begin errors++; $display("FAIL single_pulse_width: got %0d wide pulses expected 0", wide); end
  endtask

  task automatic test_back_to_back();
    int d;
    logic [7:0] g0, g1;
    baud_set = 3'd0;
    d = exp_div(3'd0);
    clear_mon();
    send_frame(8'h00, d, 1'b1, 1'b0);
    send_frame(8'hFF, d, 1'b1, 1'b0);
    idle(4);
    exp_last = 8'hFF;
    g0 = (done_q.size() > 0) ? done_q[0] : 8'hxx;
    g1 = (done_q.size() > 1) ? done_q[1] : 8'hxx;
    checks++; if (done_q.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", done_q.size()); end
    checks++; if (g0 !== 8'h00) begin errors++; $display("FAIL b2b_first: got %0h expected 00", g0); end
    checks++; if (g1 !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %0h expected ff", g1); end
    checks++; if (err_pulses != 0 || wide != 0) begin errors++; $display("FAIL b2b_pulses: got err=%0d wide=%0d expected 0/0", err_pulses, wide); end
  endtask

  task automatic test_frame_error();
    int d;
    logic [7:0] got;
    baud_set = 3'd4;
    d = exp_div(3'd4);
    clear_mon();
    send_frame(8'h3C, d, 1'b0, 1'b0);
    idle(d);
    checks++; if (err_pulses != 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", err_pulses); end
    checks++; if (done_q.size() != 0) begin errors++; $display("FAIL ferr_done: got %0d expected 0", done_q.size()); end
    checks++; if (data_byte !== exp_last) begin errors++; $display("FAIL ferr_hold: got %0h expected %0h", data_byte, exp_last); end
    checks++; if (uart_state !== 1'b0) begin errors++; $display("FAIL ferr_state: got %0b expected 0", uart_state); end
    checks++; if (overlap != 0 || wide != 0) begin errors++; $display("FAIL ferr_excl: got overlap=%0d wide=%0d expected 0/0", overlap, wide); end
    clear_mon();
    send_frame(8'h55, d, 1'b1, 1'b0);
    idle(4);
    exp_last = 8'h55;
    got = (done_q.size() > 0) ? done_q[0] : 8'hxx;
    checks++; if (done_q.size() != 1 || got !== 8'h55) begin errors++; $display("FAIL ferr_recover: got %0d bytes first=%0h expected 1 byte 55", done_q.size(), got); end
  endtask

  task automatic test_false_start();
    int d;
    baud_set = 3'd4;
    d = exp_div(3'd4);
    clear_mon();
    uart_rx = 1'b0;
    repeat (100) @(negedge clk);
    idle(2 * d);
    checks++; if (done_q.size() != 0 || err_pulses != 0) begin errors++; $display("FAIL false_pulses: got done=%0d err=%0d expected 0/0", done_q.size(), err_pulses); end
    checks++; if (state_hi < 1 || state_hi >= d) begin errors++; $display("FAIL false_busy: got %0d cycles expected 1..%0d", state_hi, d - 1); end
    checks++; if (uart_state !== 1'b0) begin errors++; $display("FAIL false_state: got %0b expected 0", uart_state); end
  endtask

  task automatic test_glitch_majority();
    int d;
    logic [7:0] got;
    baud_set = 3'd4;
    d = exp_div(3'd4);
    clear_mon();
    send_frame(8'hC3, d, 1'b1, 1'b1);
    idle(4);
    exp_last = 8'hC3;
    got = (done_q.size() > 0) ? done_q[0] : 8'hxx;
    checks++; if (done_q.size() != 1 || got !== 8'hC3) begin errors++; $display("FAIL glitch_data: got %0d bytes first=%0h expected 1 byte c3", done_q.size(), got); end
    checks++; if (err_pulses != 0) begin errors++; $display("FAIL glitch_err: got %0d expected 0", err_pulses); end
  endtask

  task automatic test_reset_mid_frame();
    int d;
    logic [9:0] bits;
    logic [7:0] got;
    baud_set = 3'd4;
    d = exp_div(3'd4);
    bits = {1'b1, 8'h81, 1'b0};
    clear_mon();
    for (int k = 0; k < 4; k++) begin
      uart_rx = bits[k];
      repeat (d) @(negedge clk);
    end
    repeat (d / 2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (data_byte !== 8'h00 || rx_done !== 1'b0 || frame_err !== 1'b0 || uart_state !== 1'b0)
      begin errors++; $display("FAIL midreset_outputs: got data=%0h done=%0b err=%0b state=%0b expected 00/0/0/0", data_byte, rx_done, frame_err, uart_state); end
    reset = 1'b0;
    exp_last = 8'h00;
    idle(2 * d);
    checks++; if (done_q.size() != 0 || err_pulses != 0) begin errors++; $display("FAIL midreset_pulses: got done=%0d err=%0d expected 0/0", done_q.size(), err_pulses); end
    clear_mon();
    send_frame(8'h81, d, 1'b1, 1'b0);
    idle(4);
    exp_last = 8'h81;
    got = (done_q.size() > 0) ? done_q[0] : 8'hxx;
    checks++; if (done_q.size() != 1 || got !== 8'h81) begin errors++; $display("FAIL midreset_next: got %0d bytes first=%0h expected 1 byte 81", done_q.size(), got); end
  endtask

  task automatic test_random_frames();
    int d;
    logic [2:0] bs;
    logic [7:0] b, got;
    for (int n = 0; n < 3; n++) begin
      bs = 3'($urandom_range(3, 4));
      b  = 8'($urandom);
      baud_set = bs;
      d = exp_div(bs);
      clear_mon();
      fork
        send_frame(b, d, 1'b1, 1'b0);
        begin
          repeat (2 * d) @(negedge clk);
          baud_set = 3'($urandom_range(0, 7));
        end
      join
      idle(4 + $urandom_range(0, 20));
      exp_last = b;
      got = (done_q.size() > 0) ? done_q[0] : 8'hxx;
      checks++; if (done_q.size() != 1 || got !== b) begin errors++; $display("FAIL random_frame%0d: got %0d bytes first=%0h expected 1 byte %0h", n, done_q.size(), got, b); end
      checks++; if (err_pulses != 0) begin errors++; $display("FAIL random_err%0d: got %0d expected 0", n, err_pulses); end
    end
  endtask

  // A 400-clock low pulse is a false start only if codes 5..7 select the 9600 period.
  task automatic test_baud_decode();
    int d0;
    baud_set = 3'(5 + $urandom_range(0, 2));
    d0 = exp_div(3'd0);
    clear_mon();
    uart_rx = 1'b0;
    repeat (400) @(negedge clk);
    idle(1400);
    checks++; if (done_q.size() != 0 || err_pulses != 0) begin errors++; $display("FAIL decode_pulses: got done=%0d err=%0d expected 0/0", done_q.size(), err_pulses); end
    checks++; if (state_hi < d0 / 2 || state_hi > d0 / 2 + 8) begin errors++; $display("FAIL decode_busy: got %0d cycles expected %0d..%0d", state_hi, d0 / 2, d0 / 2 + 8); end
    checks++; if (data_byte !== exp_last) begin errors++; $display("FAIL decode_hold: got %0h expected %0h", data_byte, exp_last); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_error();
    test_false_start();
    test_glitch_majority();
    test_reset_mid_frame();
    test_random_frames();
    test_baud_decode();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
